// File: rtl/button_conditioner.sv
// Push-button front end: per-channel two-flop synchroniser, counter-based
// debounce and a registered single-cycle strobe on each accepted press.
module button_conditioner #(
  parameter int BUTTONS         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_BITS        = 20
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [BUTTONS-1:0] i_buttons,
  output logic [BUTTONS-1:0] o_stable,
  output logic [BUTTONS-1:0] o_pulses
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [BUTTONS-1:0]  s1_q;
  logic [BUTTONS-1:0]  s2_q;
  logic [BUTTONS-1:0]  stable_q;
  logic [BUTTONS-1:0]  stable_d;
  logic [BUTTONS-1:0]  pulses_q;
  logic [BUTTONS-1:0]  pulses_d;
  logic [CNT_BITS-1:0] cnt_q [BUTTONS];
  logic [CNT_BITS-1:0] cnt_d [BUTTONS];

  // Any sample agreeing with the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
        end
      end
    end
    pulses_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      pulses_q <= '0;
      for (int i = 0; i < BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= i_buttons;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      pulses_q <= pulses_d;
      for (int i = 0; i < BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_stable = stable_q;
  assign o_pulses = pulses_q;

endmodule
